multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Moore-style multicycle control FSM that sequences the MIPS multicycle datapath: one instruction = IF, ID, then 1–3 execute/memory/writeback states.
Decodes the latched instruction register and drives every datapath select/enable, including the coprocessor-0 trap controls.
Stalls on MIO_ready for fetch and data memory, and traps to 0x80000180 on illegal opcode or arithmetic overflow.

Parameters:
none (state and ALU encodings are fixed below)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
Inst_in  in  32  latched instruction (Inst_R from datapath)
zero  in  1  ALU zero flag
overflow  in  1  ALU signed overflow flag
MIO_ready  in  1  memory/IO access complete this cycle
MemRead  out  1  memory read strobe
MemWrite  out  1  memory write strobe
CPU_MIO  out  1  bus request (MemRead|MemWrite)
IorD  out  1  1=address from PC, 0=ALU_Out
IRWrite  out  1  load instruction register
RegDst  out  2  00 rt, 01 rd, 10 $31
RegWrite  out  1  register file write enable
MemtoReg  out  3  000 ALU_Out, 001 MDR, 010 {imm,16'h0}, 011 PC, 100 CP0
ALUSrcA  out  1  0 rs, 1 PC
ALUSrcB  out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
PCSource  out  2  00 ALU res, 01 ALU_Out, 10 jump target, 11 trap vector
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  conditional PC load (branch)
Beq  out  1  1=taken on zero (beq), 0=taken on !zero (bne)
ALU_operation  out  3  000 and, 001 or, 010 add, 110 sub, 111 slt, 100 nor, 101 srl, 011 xor
EPCWrite  out  1  capture ALU res into EPC
CauseWrite  out  1  capture IntCause
IntCause  out  2  01 illegal instruction, 10 overflow, else 00
Co0Write  out  1  CP0 register write; always 0 in this revision
state_out  out  5  current state code, for debug display

Behaviour:
- State register resets asynchronously to IF (0). All outputs are pure decode of state, plus Inst_in in states after ID. Unlisted outputs = 0 in every state, so during reset outputs equal the IF decode.
- IF (0): IorD=1, MemRead=1, IRWrite=1, ALUSrcA=1, ALUSrcB=01, add, PCWrite=1, PCSource=00. Hold in IF while !MIO_ready; go to ID on the MIO_ready cycle.
- ID (1): ALUSrcA=1, ALUSrcB=11, add (branch target into ALU_Out). Dispatch on opcode Inst_in[31:26]:
  - lw/sw -> MA
  - R-type with a legal funct -> EXR
  - jr (funct 001000) -> JR1
  - beq/bne -> BR
  - addi/slti -> EXI
  - lui -> LUI
  - j -> J
  - jal -> JAL
  - mfc0 (opcode 010000, rs=00000) -> MFC0
  - anything else -> TRAP with IntCause=01
- MA (2): ALUSrcA=0, ALUSrcB=10, add. Goes to MR for lw, MW for sw.
- MR (3): IorD=0, MemRead=1; hold until MIO_ready, then WL.
- WL (4): RegDst=00, MemtoReg=001, RegWrite=1, then IF.
- MW (5): IorD=0, MemWrite=1; hold until MIO_ready, then IF.
- EXR (6): ALUSrcA=0, ALUSrcB=00, ALU_operation from funct:
  - add 100000 / addu 100001 -> add; sub 100010 / subu 100011 -> sub
  - and -> and; or -> or; xor -> xor; nor -> nor; slt -> slt; srl -> srl
  - Next: TRAP with IntCause=10 if overflow and funct is add or sub (not addu/subu); else WR.
- WR (7): RegDst=01, MemtoReg=000, RegWrite=1, then IF.
- EXI (8): ALUSrcA=0, ALUSrcB=10, add (addi) or slt (slti). Next: overflow on addi -> TRAP with IntCause=10; else WI.
- WI (9): RegDst=00, MemtoReg=000, RegWrite=1, then IF.
- LUI (10): RegDst=00, MemtoReg=010, RegWrite=1, then IF.
- BR (11): ALUSrcA=0, ALUSrcB=00, sub, PCWriteCond=1, PCSource=01, Beq=(opcode==beq). Then IF.
- J (12): PCWrite=1, PCSource=10, then IF.
- JAL (13): PCWrite=1, PCSource=10, RegDst=10, MemtoReg=011, RegWrite=1. $31 receives the pre-edge PC (already PC+4). Then IF.
- JR1 (14): ALUSrcA=0, ALUSrcB=00, add (rt field is $0, so ALU_Out=rs), then JR2.
- JR2 (15): PCWrite=1, PCSource=01, then IF.
- MFC0 (16): RegDst=00, MemtoReg=100, RegWrite=1, then IF.
- TRAP (17): ALUSrcA=1, ALUSrcB=01, sub (res = faulting instruction address), EPCWrite=1, CauseWrite=1, IntCause held from entry (registered 2-bit cause), PCWrite=1, PCSource=11. Then IF.
- Overflow trap suppresses writeback: no RegWrite occurs for the faulting instruction.
- Reset mid-state (including mid-stall): immediate return to IF; cause register cleared to 00.
- MIO_ready is ignored in states that make no memory access.

Test Plan:
- Reset then MIO_ready=1: state_out=0, IorD=1, MemRead=1, PCWrite=1. Next edge state_out=1; hold MIO_ready=0 for 3 cycles in IF -> state stays 0 for those 3 cycles.
- lw 0x8C410004 with MIO_ready dropped 2 cycles in MR -> sequence 0,1,2,3,3,3,4,0. In state 4, RegWrite=1, MemtoReg=001, RegDst=00.
- add 0x00221820 with overflow=1 in EXR -> states 0,1,6,17. In 17: EPCWrite=1, CauseWrite=1, IntCause=10, PCSource=11. No RegWrite asserted.
- bne 0x14220003 -> state 11 with Beq=0, PCWriteCond=1, PCSource=01, ALU_operation=110. beq 0x10220003 -> Beq=1.
- jal 0x0C000010 -> states 0,1,13 with RegDst=10, MemtoReg=011, PCSource=10 simultaneously. jr 0x03E00008 -> 14,15 with PCSource=01 in 15.
- Opcode 0x3F -> ID to TRAP with IntCause=01. Assert reset while in MR -> state_out=0 asynchronously.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences IF, ID and 1-3 execute/memory/writeback states and drives every datapath select.
// Latency: outputs are registered alongside the state, so they always equal the decode of state_out; each state lasts one cycle unless stalled.
// Backpressure: holds in IF, MR and MW until MIO_ready; every other state ignores MIO_ready.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Inst_in,
  input  logic        zero,
  input  logic        overflow,
  input  logic        MIO_ready,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        CPU_MIO,
  output logic        IorD,
  output logic        IRWrite,
  output logic [1:0]  RegDst,
  output logic        RegWrite,
  output logic [2:0]  MemtoReg,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  PCSource,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        Beq,
  output logic [2:0]  ALU_operation,
  output logic        EPCWrite,
  output logic        CauseWrite,
  output logic [1:0]  IntCause,
  output logic        Co0Write,
  output logic [4:0]  state_out
);

  typedef enum logic [4:0] {
    S_IF = 5'd0, S_ID = 5'd1, S_MA = 5'd2, S_MR = 5'd3, S_WL = 5'd4, S_MW = 5'd5,
    S_EXR = 5'd6, S_WR = 5'd7, S_EXI = 5'd8, S_WI = 5'd9, S_LUI = 5'd10, S_BR = 5'd11,
    S_J = 5'd12, S_JAL = 5'd13, S_JR1 = 5'd14, S_JR2 = 5'd15, S_MFC0 = 5'd16, S_TRAP = 5'd17
  } state_t;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic       reg_write;
    logic [2:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       pc_write;
    logic       pc_write_cond;
    logic       beq;
    logic [2:0] alu_op;
    logic       epc_write;
    logic       cause_write;
    logic [1:0] int_cause;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_SLTI = 6'h0A, OP_LUI = 6'h0F;
  localparam logic [5:0] OP_COP0 = 6'h10, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] F_SRL = 6'h02, F_JR = 6'h08, F_ADD = 6'h20, F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB = 6'h22, F_SUBU = 6'h23, F_AND = 6'h24, F_OR = 6'h25;
  localparam logic [5:0] F_XOR = 6'h26, F_NOR = 6'h27, F_SLT = 6'h2A;
  localparam logic [2:0] ALU_AND = 3'b000, ALU_OR = 3'b001, ALU_ADD = 3'b010, ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100, ALU_SRL = 3'b101, ALU_SUB = 3'b110, ALU_SLT = 3'b111;

  state_t     state, nxt;
  logic [1:0] cause, nxt_cause;
  ctrl_t      ctrl;

  // The branch decision on zero is made in the datapath from PCWriteCond/Beq, not here.
  logic unused_zero;
  assign unused_zero = zero;

  function automatic logic [2:0] r_alu_op(input logic [5:0] fn);
    logic [2:0] op;
    op = ALU_ADD;
    case (fn)
      F_ADD, F_ADDU: op = ALU_ADD;
      F_SUB, F_SUBU: op = ALU_SUB;
      F_AND:         op = ALU_AND;
      F_OR:          op = ALU_OR;
      F_XOR:         op = ALU_XOR;
      F_NOR:         op = ALU_NOR;
      F_SLT:         op = ALU_SLT;
      F_SRL:         op = ALU_SRL;
      default:       op = ALU_ADD;
    endcase
    return op;
  endfunction

  function automatic logic r_alu_legal(input logic [5:0] fn);
    logic ok;
    ok = 1'b0;
    case (fn)
      F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SRL: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic state_t next_state(input state_t s, input logic [31:0] inst,
                                        input logic rdy, input logic ovf);
    state_t     n;
    logic [5:0] op;
    logic [5:0] fn;
    n  = S_IF;
    op = inst[31:26];
    fn = inst[5:0];
    case (s)
      S_IF: n = rdy ? S_ID : S_IF;
      S_ID: begin
        case (op)
          OP_RTYPE: begin
            if (fn == F_JR)            n = S_JR1;
            else if (r_alu_legal(fn))  n = S_EXR;
            else                       n = S_TRAP;
          end
          OP_LW, OP_SW:     n = S_MA;
          OP_BEQ, OP_BNE:   n = S_BR;
          OP_ADDI, OP_SLTI: n = S_EXI;
          OP_LUI:           n = S_LUI;
          OP_J:             n = S_J;
          OP_JAL:           n = S_JAL;
          OP_COP0:          n = (inst[25:21] == 5'd0) ? S_MFC0 : S_TRAP;
          default:          n = S_TRAP;
        endcase
      end
      S_MA:  n = (op == OP_LW) ? S_MR : S_MW;
      S_MR:  n = rdy ? S_WL : S_MR;
      S_MW:  n = rdy ? S_IF : S_MW;
      // Only the signed add/sub trap; addu/subu ignore the overflow flag.
      S_EXR: n = (ovf && (fn == F_ADD || fn == F_SUB)) ? S_TRAP : S_WR;
      S_EXI: n = (ovf && op == OP_ADDI) ? S_TRAP : S_WI;
      S_JR1: n = S_JR2;
      default: n = S_IF;
    endcase
    return n;
  endfunction

  function automatic ctrl_t decode(input state_t s, input logic [31:0] inst, input logic [1:0] c);
    ctrl_t o;
    o = '0;
    case (s)
      S_IF: begin
        o.iord = 1'b1; o.mem_read = 1'b1; o.ir_write = 1'b1; o.alu_src_a = 1'b1;
        o.alu_src_b = 2'b01; o.alu_op = ALU_ADD; o.pc_write = 1'b1; o.pc_source = 2'b00;
      end
      S_ID:  begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b11; o.alu_op = ALU_ADD; end
      S_MA:  begin o.alu_src_b = 2'b10; o.alu_op = ALU_ADD; end
      S_MR:  o.mem_read = 1'b1;
      S_WL:  begin o.mem_to_reg = 3'b001; o.reg_write = 1'b1; end
      S_MW:  o.mem_write = 1'b1;
      S_EXR: o.alu_op = r_alu_op(inst[5:0]);
      S_WR:  begin o.reg_dst = 2'b01; o.reg_write = 1'b1; end
      S_EXI: begin
        o.alu_src_b = 2'b10;
        o.alu_op    = (inst[31:26] == OP_SLTI) ? ALU_SLT : ALU_ADD;
      end
      S_WI:  o.reg_write = 1'b1;
      S_LUI: begin o.mem_to_reg = 3'b010; o.reg_write = 1'b1; end
      S_BR:  begin
        o.alu_op = ALU_SUB; o.pc_write_cond = 1'b1; o.pc_source = 2'b01;
        o.beq    = (inst[31:26] == OP_BEQ);
      end
      S_J:   begin o.pc_write = 1'b1; o.pc_source = 2'b10; end
      // PC already holds PC+4 here, so $31 gets the correct return address.
      S_JAL: begin
        o.pc_write = 1'b1; o.pc_source = 2'b10; o.reg_dst = 2'b10;
        o.mem_to_reg = 3'b011; o.reg_write = 1'b1;
      end
      S_JR1: o.alu_op = ALU_ADD;
      S_JR2: begin o.pc_write = 1'b1; o.pc_source = 2'b01; end
      S_MFC0: begin o.mem_to_reg = 3'b100; o.reg_write = 1'b1; end
      // PC-4 recovers the faulting instruction's address for EPC.
      S_TRAP: begin
        o.alu_src_a = 1'b1; o.alu_src_b = 2'b01; o.alu_op = ALU_SUB;
        o.epc_write = 1'b1; o.cause_write = 1'b1; o.int_cause = c;
        o.pc_write  = 1'b1; o.pc_source = 2'b11;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

  assign nxt = next_state(state, Inst_in, MIO_ready, overflow);
  // Cause is latched on the edge that enters TRAP: illegal from ID, overflow from execute.
  assign nxt_cause = (nxt == S_TRAP && state != S_TRAP) ? ((state == S_ID) ? 2'b01 : 2'b10) : cause;

  // State, cause and the registered decode of the next state advance together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IF;
      cause <= 2'b00;
      ctrl  <= decode(S_IF, 32'd0, 2'b00);
    end else begin
      state <= nxt;
      cause <= nxt_cause;
      ctrl  <= decode(nxt, Inst_in, nxt_cause);
    end
  end

  assign MemRead       = ctrl.mem_read;
  assign MemWrite      = ctrl.mem_write;
  assign CPU_MIO       = ctrl.mem_read | ctrl.mem_write;
  assign IorD          = ctrl.iord;
  assign IRWrite       = ctrl.ir_write;
  assign RegDst        = ctrl.reg_dst;
  assign RegWrite      = ctrl.reg_write;
  assign MemtoReg      = ctrl.mem_to_reg;
  assign ALUSrcA       = ctrl.alu_src_a;
  assign ALUSrcB       = ctrl.alu_src_b;
  assign PCSource      = ctrl.pc_source;
  assign PCWrite       = ctrl.pc_write;
  assign PCWriteCond   = ctrl.pc_write_cond;
  assign Beq           = ctrl.beq;
  assign ALU_operation = ctrl.alu_op;
  assign EPCWrite      = ctrl.epc_write;
  assign CauseWrite    = ctrl.cause_write;
  assign IntCause      = ctrl.int_cause;
  assign Co0Write      = 1'b0;
  assign state_out     = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed instruction sequences plus randomized instruction/stall/overflow traffic.
// A plan-based instruction model predicts state and every control output each cycle.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       cpu_mio;
    logic       iord;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic       reg_write;
    logic [2:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       pc_write;
    logic       pc_write_cond;
    logic       beq;
    logic [2:0] alu_op;
    logic       epc_write;
    logic       cause_write;
    logic [1:0] int_cause;
    logic       co0_write;
  } cv_t;

  logic clk = 1'b0;
  logic reset, zero, overflow, MIO_ready;
  logic [31:0] Inst_in;
  logic MemRead, MemWrite, CPU_MIO, IorD, IRWrite, RegWrite, ALUSrcA, PCWrite, PCWriteCond, Beq;
  logic EPCWrite, CauseWrite, Co0Write;
  logic [1:0] RegDst, ALUSrcB, PCSource, IntCause;
  logic [2:0] MemtoReg, ALU_operation;
  logic [4:0] state_out;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .Inst_in(Inst_in), .zero(zero), .overflow(overflow),
    .MIO_ready(MIO_ready), .MemRead(MemRead), .MemWrite(MemWrite), .CPU_MIO(CPU_MIO),
    .IorD(IorD), .IRWrite(IRWrite), .RegDst(RegDst), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .Beq(Beq), .ALU_operation(ALU_operation), .EPCWrite(EPCWrite),
    .CauseWrite(CauseWrite), .IntCause(IntCause), .Co0Write(Co0Write), .state_out(state_out)
  );

  int n_pass = 0;
  int n_total = 0;

  // Model: current state, states still to visit for this instruction, latched trap cause.
  logic [4:0]  mst = 5'd0;
  logic [4:0]  plan[$];
  logic [1:0]  mcause = 2'd0;
  logic [31:0] fetch_instr = 32'd0;
  logic        cmp_en = 1'b0;
  logic        rec = 1'b0;
  string       trace;
  cv_t         trace_v[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %s expected %s", name, act, exp);
  endtask

  function automatic cv_t dut_v();
    return {MemRead, MemWrite, CPU_MIO, IorD, IRWrite, RegDst, RegWrite, MemtoReg, ALUSrcA,
            ALUSrcB, PCSource, PCWrite, PCWriteCond, Beq, ALU_operation, EPCWrite, CauseWrite,
            IntCause, Co0Write};
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] fn);
    case (fn)
      6'h20, 6'h21: return 3'b010;
      6'h22, 6'h23: return 3'b110;
      6'h24: return 3'b000;
      6'h25: return 3'b001;
      6'h26: return 3'b011;
      6'h27: return 3'b100;
      6'h2A: return 3'b111;
      6'h02: return 3'b101;
      default: return 3'b010;
    endcase
  endfunction

  // Expected control word for each state, straight from the per-state output list.
  function automatic cv_t exp_of(input logic [4:0] s, input logic [31:0] ins, input logic [1:0] c);
    cv_t v;
    v = '0;
    case (s)
      5'd0: begin v.iord = 1; v.mem_read = 1; v.ir_write = 1; v.alu_src_a = 1;
                  v.alu_src_b = 2'b01; v.alu_op = 3'b010; v.pc_write = 1; end
      5'd1: begin v.alu_src_a = 1; v.alu_src_b = 2'b11; v.alu_op = 3'b010; end
      5'd2: begin v.alu_src_b = 2'b10; v.alu_op = 3'b010; end
      5'd3: v.mem_read = 1;
      5'd4: begin v.mem_to_reg = 3'b001; v.reg_write = 1; end
      5'd5: v.mem_write = 1;
      5'd6: v.alu_op = funct_alu(ins[5:0]);
      5'd7: begin v.reg_dst = 2'b01; v.reg_write = 1; end
      5'd8: begin v.alu_src_b = 2'b10; v.alu_op = (ins[31:26] == 6'h0A) ? 3'b111 : 3'b010; end
      5'd9: v.reg_write = 1;
      5'd10: begin v.mem_to_reg = 3'b010; v.reg_write = 1; end
      5'd11: begin v.alu_op = 3'b110; v.pc_write_cond = 1; v.pc_source = 2'b01;
                   v.beq = (ins[31:26] == 6'h04); end
      5'd12: begin v.pc_write = 1; v.pc_source = 2'b10; end
      5'd13: begin v.pc_write = 1; v.pc_source = 2'b10; v.reg_dst = 2'b10;
                   v.mem_to_reg = 3'b011; v.reg_write = 1; end
      5'd14: v.alu_op = 3'b010;
      5'd15: begin v.pc_write = 1; v.pc_source = 2'b01; end
      5'd16: begin v.mem_to_reg = 3'b100; v.reg_write = 1; end
      5'd17: begin v.alu_src_a = 1; v.alu_src_b = 2'b01; v.alu_op = 3'b110; v.epc_write = 1;
                   v.cause_write = 1; v.int_cause = c; v.pc_write = 1; v.pc_source = 2'b11; end
      default: v = '0;
    endcase
    v.cpu_mio = v.mem_read | v.mem_write;
    return v;
  endfunction

  // Instruction class -> list of states it walks through after ID.
  task automatic set_plan(input logic [31:0] ins);
    logic [5:0] op, fn;
    op = ins[31:26];
    fn = ins[5:0];
    plan.delete();
    if (op == 6'h23)                        plan = '{5'd2, 5'd3, 5'd4};
    else if (op == 6'h2B)                   plan = '{5'd2, 5'd5};
    else if (op == 6'h00 && fn == 6'h08)    plan = '{5'd14, 5'd15};
    else if (op == 6'h00 && fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h02})
                                            plan = '{5'd6, 5'd7};
    else if (op == 6'h04 || op == 6'h05)    plan = '{5'd11};
    else if (op == 6'h08 || op == 6'h0A)    plan = '{5'd8, 5'd9};
    else if (op == 6'h0F)                   plan = '{5'd10};
    else if (op == 6'h02)                   plan = '{5'd12};
    else if (op == 6'h03)                   plan = '{5'd13};
    else if (op == 6'h10 && ins[25:21] == 5'd0) plan = '{5'd16};
    else begin plan = '{5'd17}; mcause = 2'd1; end
  endtask

  task automatic model_step(input logic rdy, input logic ovf);
    logic sig_ovf;
    if ((mst == 5'd0 || mst == 5'd3 || mst == 5'd5) && !rdy) return;
    if (mst == 5'd0) begin mst = 5'd1; return; end
    sig_ovf = (mst == 5'd6 && (Inst_in[5:0] == 6'h20 || Inst_in[5:0] == 6'h22)) ||
              (mst == 5'd8 && Inst_in[31:26] == 6'h08);
    if (mst == 5'd1) set_plan(Inst_in);
    else if (ovf && sig_ovf) begin plan.delete(); plan.push_back(5'd17); mcause = 2'd2; end
    mst = (plan.size() == 0) ? 5'd0 : plan.pop_front();
  endtask

  task automatic step(input logic rdy, input logic ovf);
    MIO_ready = rdy;
    overflow  = ovf;
    zero      = 1'($urandom);
    @(posedge clk);
    #1;
    model_step(rdy, ovf);
    if (mst == 5'd1) Inst_in = fetch_instr;  // IR captured on the fetch-complete edge
    if (rec) begin
      trace = {trace, $sformatf(",%0d", state_out)};
      trace_v.push_back(dut_v());
    end
  endtask

  task automatic run_seq(input string name, input logic [31:0] ins, input logic [7:0] rdy,
                         input logic [7:0] ovf, input int n, input string exp_states);
    fetch_instr = ins;
    trace = $sformatf("%0d", state_out);
    trace_v.delete();
    trace_v.push_back(dut_v());
    rec = 1'b1;
    for (int i = 0; i < n; i++) step(rdy[i], ovf[i]);
    rec = 1'b0;
    chk_str(name, trace, exp_states);
  endtask

  task automatic async_reset(input string name);
    #1 reset = 1'b1;
    #1;
    chk({name, "_state"}, {27'd0, state_out}, 32'd0);
    chk({name, "_ifdecode"}, {29'd0, IorD, MemRead, PCWrite}, 32'd7);
    mst = 5'd0;
    mcause = 2'd0;
    plan.delete();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 10))
      0: r[31:26] = 6'h23;
      1: r[31:26] = 6'h2B;
      2: begin
        r[31:26] = 6'h00;
        case ($urandom_range(0, 11))
          0: r[5:0] = 6'h20;  1: r[5:0] = 6'h21;  2: r[5:0] = 6'h22;  3: r[5:0] = 6'h23;
          4: r[5:0] = 6'h24;  5: r[5:0] = 6'h25;  6: r[5:0] = 6'h26;  7: r[5:0] = 6'h27;
          8: r[5:0] = 6'h2A;  9: r[5:0] = 6'h02;  10: r[5:0] = 6'h08;
          default: ;
        endcase
      end
      3: r = {6'h00, r[25:21], 15'd0, 6'h08};
      4: r[31:26] = ($urandom_range(0, 1) == 1) ? 6'h04 : 6'h05;
      5: r[31:26] = ($urandom_range(0, 1) == 1) ? 6'h08 : 6'h0A;
      6: r[31:26] = 6'h0F;
      7: r[31:26] = 6'h02;
      8: r[31:26] = 6'h03;
      9: begin r[31:26] = 6'h10; if ($urandom_range(0, 2) != 0) r[25:21] = 5'd0; end
      default: ;
    endcase
    return r;
  endfunction

  // Every negedge: DUT state and full control word against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("state_out", {27'd0, state_out}, {27'd0, mst});
      chk("ctrl_word", {4'd0, dut_v()}, {4'd0, exp_of(mst, Inst_in, mcause)});
    end
  end

  initial begin
    reset = 1'b1;
    MIO_ready = 1'b1;
    overflow = 1'b0;
    zero = 1'b0;
    Inst_in = 32'd0;
    cmp_en = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_state", {27'd0, state_out}, 32'd0);
    chk("reset_iord_memread_pcwrite", {29'd0, IorD, MemRead, PCWrite}, 32'd7);

    run_seq("sw_if_hold", 32'hAC410004, 8'b0111_1000, 8'h00, 7, "0,0,0,0,1,2,5,0");

    run_seq("lw_mr_stall", 32'h8C410004, 8'b0110_0111, 8'h00, 7, "0,1,2,3,3,3,4,0");
    chk("lw_wl_fields", {26'd0, trace_v[6].reg_write, trace_v[6].mem_to_reg, trace_v[6].reg_dst},
        32'b1_001_00);

    run_seq("add_ovf", 32'h00221820, 8'hFF, 8'b0000_0100, 4, "0,1,6,17,0");
    chk("add_ovf_trap_fields", {25'd0, trace_v[3].epc_write, trace_v[3].cause_write,
        trace_v[3].int_cause, trace_v[3].pc_source, trace_v[3].reg_write}, 32'b1_1_10_11_0);
    chk("add_ovf_no_regwrite", {28'd0, trace_v[1].reg_write, trace_v[2].reg_write,
        trace_v[3].reg_write, trace_v[4].reg_write}, 32'd0);

    run_seq("bne", 32'h14220003, 8'hFF, 8'h00, 3, "0,1,11,0");
    chk("bne_fields", {24'd0, trace_v[2].beq, trace_v[2].pc_write_cond, trace_v[2].pc_source,
        trace_v[2].alu_op}, 32'b0_1_01_110);
    run_seq("beq", 32'h10220003, 8'hFF, 8'h00, 3, "0,1,11,0");
    chk("beq_flag", {31'd0, trace_v[2].beq}, 32'd1);

    run_seq("jal", 32'h0C000010, 8'hFF, 8'h00, 3, "0,1,13,0");
    chk("jal_fields", {25'd0, trace_v[2].reg_dst, trace_v[2].mem_to_reg, trace_v[2].pc_source},
        32'b10_011_10);
    run_seq("jr", 32'h03E00008, 8'hFF, 8'h00, 4, "0,1,14,15,0");
    chk("jr2_pcsource", {30'd0, trace_v[3].pc_source}, 32'd1);

    run_seq("illegal_op", 32'hFC000000, 8'hFF, 8'h00, 3, "0,1,17,0");
    chk("illegal_cause", {30'd0, trace_v[2].int_cause}, 32'd1);

    run_seq("lw_to_mr", 32'h8C410004, 8'b0000_0111, 8'h00, 4, "0,1,2,3,3");
    async_reset("reset_in_mr");

    for (int i = 0; i < 3000; i++) begin
      fetch_instr = rand_instr();
      step($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 199) == 0) async_reset("rand_reset");
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
